// File: rtl/sim_uart_monitor_pkg.sv
// Shared types and constants for the simulation UART monitor.
// Holds the receiver state encoding, ASCII control codes and the drop counter helper.
package sim_uart_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam int         DROP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sim_uart_rx_deser.sv
// 8N1 deserialiser: input synchroniser, baud counter and receive FSM.
// Emits a registered byte with one-cycle valid and frame-error strobes.
module sim_uart_rx_deser
  import sim_uart_monitor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_q, rx_sync_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_d       = shift_q;
            byte_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/sim_uart_monitor.sv
// UART console monitor: deserialises the SoC uart_tx pin and assembles bytes into lines.
// Define SIM_UART_MONITOR_PRINT_EN to echo received text and frame errors to the sim console.
module sim_uart_monitor
  import sim_uart_monitor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int LINE_LEN     = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  output logic [7:0]                    byte_o,
  output logic                          byte_valid_o,
  output logic                          frame_err_o,
  output logic                          line_valid_o,
  output logic [$clog2(LINE_LEN):0]     line_len_o,
  input  logic [$clog2(LINE_LEN)-1:0]   line_rd_addr_i,
  output logic [7:0]                    line_rd_data_o,
  input  logic                          line_ack_i,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o
);

  localparam int ADDR_W = $clog2(LINE_LEN);
  localparam int LEN_W  = ADDR_W + 1;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  sim_uart_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_deser (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                  line_valid_q, line_valid_d;
  logic [LEN_W-1:0]      line_len_q, line_len_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  mem_we;
  logic [7:0]            line_mem [LINE_LEN];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    line_valid_d = line_valid_q;
    line_len_d   = line_len_q;
    drop_cnt_d   = drop_cnt_q;
    mem_we       = 1'b0;

    if (rx_valid) begin
      if (line_valid_q) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
      end else if (rx_byte == ASCII_LF) begin
        line_valid_d = 1'b1;
        line_len_d   = {1'b0, wr_ptr_q};
        wr_ptr_d     = '0;
      end else if (rx_byte != ASCII_CR) begin
        mem_we = 1'b1;
        // A full buffer closes the line without waiting for a terminator.
        if (&wr_ptr_q) begin
          line_valid_d = 1'b1;
          line_len_d   = LEN_W'(LINE_LEN);
          wr_ptr_d     = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
    end

    // The flag is sampled above first, so a byte landing in the ack cycle is still dropped.
    if (line_valid_q && line_ack_i) line_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      line_valid_q <= 1'b0;
      line_len_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      line_valid_q <= line_valid_d;
      line_len_q   <= line_len_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // NOTE: the line storage has no reset; contents are only meaningful under line_valid_o.
  always_ff @(posedge clk_i) begin
    if (mem_we) line_mem[wr_ptr_q] <= rx_byte;
  end

  assign byte_o         = rx_byte;
  assign byte_valid_o   = rx_valid;
  assign frame_err_o    = rx_err;
  assign line_valid_o   = line_valid_q;
  assign line_len_o     = line_len_q;
  assign line_rd_data_o = line_mem[line_rd_addr_i];
  assign drop_cnt_o     = drop_cnt_q;

`ifdef SIM_UART_MONITOR_PRINT_EN
  always @(posedge clk_i) begin
    if (rx_valid && rx_byte != ASCII_CR) $write("%c", rx_byte);
    if (rx_err) $display("[%0t] sim_uart_monitor: frame error", $time);
  end
`else
  // Console echo compiled out; port behaviour is unchanged.
`endif

endmodule
